// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: screen geometry, obstacle sprite
// encoding and the run-state enum.
package game_pkg;

    localparam int X_W      = 10;
    localparam int SCREEN_W = 640;
    localparam int STEP     = 2;

    typedef enum logic [1:0] {
        CACTUS_SMALL = 2'd0,
        CACTUS_BIG   = 2'd1,
        CACTUS_PAIR  = 2'd2,
        BIRD         = 2'd3
    } obs_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } game_state_e;

endpackage

// File: rtl/tick_gen.sv
// Scroll tick generator: clamps the incoming period to a floor, latches it at
// each reload and counts down, pulsing tick for one cycle when the count is 0.
module tick_gen #(
    parameter int                 SPEED_W    = 21,
    parameter logic [SPEED_W-1:0] MIN_PERIOD = 21'd50000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [SPEED_W-1:0] speed,
    input  logic               load,
    input  logic               run,
    output logic               tick
);

    logic [SPEED_W-1:0] cnt_q;
    logic [SPEED_W-1:0] eff;

    // Upstream can wrap below the floor; anything under it is clamped.
    assign eff = (speed < MIN_PERIOD) ? MIN_PERIOD : speed;

    // Down-counter: loaded on run entry, reloaded at zero, held when not running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= eff - SPEED_W'(1);
        end else if (run) begin
            if (cnt_q == '0) cnt_q <= eff - SPEED_W'(1);
            else             cnt_q <= cnt_q - SPEED_W'(1);
        end
    end

    assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/obstacle_scroller.sv
// Obstacle scroller: two ground-obstacle slots that step left on every scroll
// tick, retire off the left edge (counted in passed) and respawn at the right
// edge after an LFSR-randomised gap.
module obstacle_scroller #(
    parameter int                 SPEED_W    = 21,
    parameter int                 X_W        = game_pkg::X_W,
    parameter int                 SCREEN_W   = game_pkg::SCREEN_W,
    parameter int                 STEP       = game_pkg::STEP,
    parameter logic [SPEED_W-1:0] MIN_PERIOD = 21'd50000,
    parameter logic [7:0]         GAP_MIN    = 8'd60
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [SPEED_W-1:0] speed,
    input  logic               start,
    input  logic               crash,
    output logic               tick,
    output logic               running,
    output logic               obs0_valid,
    output logic [X_W-1:0]     obs0_x,
    output logic [1:0]         obs0_type,
    output logic               obs1_valid,
    output logic [X_W-1:0]     obs1_x,
    output logic [1:0]         obs1_type,
    output logic [15:0]        passed
);
    import game_pkg::*;

    localparam logic [X_W-1:0] STEP_X  = X_W'(STEP);
    localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_W - 1);

    game_state_e    state_q, state_d;
    logic           run_init;
    logic [15:0]    lfsr_q;
    logic [1:0]     v_q, v_d;
    logic [X_W-1:0] x_q [2];
    logic [X_W-1:0] x_d [2];
    logic [1:0]     t_q [2];
    logic [1:0]     t_d [2];
    logic [7:0]     gap_q, gap_d;
    logic [15:0]    passed_q, passed_d;
    logic [1:0]     retired;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    tick_gen #(
        .SPEED_W    (SPEED_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_tick_gen (
        .clk   (clk),
        .rstn  (rstn),
        .speed (speed),
        .load  (run_init),
        .run   (running),
        .tick  (tick)
    );

    // Free-running LFSR (taps 16,14,13,11), only reseeded by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Run-state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state; crash wins over start while running, start is ignored in RUN.
    always_comb begin
        state_d  = state_q;
        run_init = 1'b0;
        case (state_q)
            IDLE, HALT: if (start) begin
                state_d  = RUN;
                run_init = 1'b1;
            end
            RUN:     if (crash) state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign running = (state_q == RUN);

    // Per-tick slot update: move/retire first, then spawn into a freed slot.
    always_comb begin
        v_d      = v_q;
        x_d      = x_q;
        t_d      = t_q;
        gap_d    = gap_q;
        retired  = 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (v_q[i]) begin
                if (x_q[i] < STEP_X) begin
                    v_d[i]  = 1'b0;
                    retired = retired + 2'd1;
                end else begin
                    x_d[i] = x_q[i] - STEP_X;
                end
            end
        end
        passed_d = sat_add16(passed_q, retired);
        if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
        end else if (!v_d[0]) begin
            v_d[0] = 1'b1;
            x_d[0] = SPAWN_X;
            t_d[0] = lfsr_q[1:0];
            gap_d  = GAP_MIN + {2'b00, lfsr_q[7:2]};
        end else if (!v_d[1]) begin
            v_d[1] = 1'b1;
            x_d[1] = SPAWN_X;
            t_d[1] = lfsr_q[1:0];
            gap_d  = GAP_MIN + {2'b00, lfsr_q[7:2]};
        end
    end

    // Slot registers: cleared on run entry, advanced on ticks not cut by a crash.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q      <= 2'b00;
            x_q[0]   <= '0;
            x_q[1]   <= '0;
            t_q[0]   <= 2'd0;
            t_q[1]   <= 2'd0;
            gap_q    <= GAP_MIN;
            passed_q <= 16'd0;
        end else if (run_init) begin
            v_q      <= 2'b00;
            x_q[0]   <= '0;
            x_q[1]   <= '0;
            t_q[0]   <= 2'd0;
            t_q[1]   <= 2'd0;
            gap_q    <= GAP_MIN;
            passed_q <= 16'd0;
        end else if (tick && !crash) begin
            v_q      <= v_d;
            x_q[0]   <= x_d[0];
            x_q[1]   <= x_d[1];
            t_q[0]   <= t_d[0];
            t_q[1]   <= t_d[1];
            gap_q    <= gap_d;
            passed_q <= passed_d;
        end
    end

    assign obs0_valid = v_q[0];
    assign obs0_x     = x_q[0];
    assign obs0_type  = t_q[0];
    assign obs1_valid = v_q[1];
    assign obs1_x     = x_q[1];
    assign obs1_type  = t_q[1];
    assign passed     = passed_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller with a shrunken screen, period floor and gap so
// whole runs fit in a short simulation.
module tb_obstacle_scroller;

    localparam int SPEED_W = 21;
    localparam int X_W     = 10;
    localparam int SW      = 40;
    localparam int STEP    = 2;
    localparam int MINP    = 8;
    localparam int GAPM    = 2;

    logic               clk = 1'b0;
    logic               rstn;
    logic [SPEED_W-1:0] speed;
    logic               start, crash;
    logic               tick, running;
    logic               obs0_valid, obs1_valid;
    logic [X_W-1:0]     obs0_x, obs1_x;
    logic [1:0]         obs0_type, obs1_type;
    logic [15:0]        passed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: 0 idle, 1 run, 2 halt; m_next is the window index of the next tick.
    int          m_state;
    int          m_next;
    bit          m_v [2];
    int          m_x [2];
    logic [1:0]  m_t [2];
    int          m_passed;
    int          m_gap;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    obstacle_scroller #(
        .SPEED_W    (SPEED_W),
        .X_W        (X_W),
        .SCREEN_W   (SW),
        .STEP       (STEP),
        .MIN_PERIOD (21'(MINP)),
        .GAP_MIN    (8'(GAPM))
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .speed      (speed),
        .start      (start),
        .crash      (crash),
        .tick       (tick),
        .running    (running),
        .obs0_valid (obs0_valid),
        .obs0_x     (obs0_x),
        .obs0_type  (obs0_type),
        .obs1_valid (obs1_valid),
        .obs1_x     (obs1_x),
        .obs1_type  (obs1_type),
        .passed     (passed)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic int eff(input int s);
        return (s < MINP) ? MINP : s;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_next   = 0;
        m_passed = 0;
        m_gap    = GAPM;
        m_lfsr   = 16'hACE1;
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 0;
            m_x[i] = 0;
            m_t[i] = 2'd0;
        end
    endtask

    task automatic do_move(input logic [15:0] l);
        int ret = 0;
        int s   = -1;
        for (int i = 0; i < 2; i++) begin
            if (m_v[i]) begin
                if (m_x[i] < STEP) begin
                    m_v[i] = 0;
                    ret++;
                end else begin
                    m_x[i] = m_x[i] - STEP;
                end
            end
        end
        m_passed = (m_passed + ret > 65535) ? 65535 : m_passed + ret;
        if (m_gap > 0) begin
            m_gap--;
        end else begin
            if (!m_v[0])      s = 0;
            else if (!m_v[1]) s = 1;
            if (s >= 0) begin
                m_v[s] = 1;
                m_x[s] = SW - 1;
                m_t[s] = l[1:0];
                m_gap  = GAPM + int'(l[7:2]);
            end
        end
    endtask

    // Applies one clock edge to the model using the inputs of the window just ended.
    task automatic model_edge();
        logic [15:0] l;
        bit          tk;
        l = m_lfsr;
        cyc++;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (m_state != 1) begin
            if (start) begin
                m_state  = 1;
                m_passed = 0;
                m_gap    = GAPM;
                for (int i = 0; i < 2; i++) begin
                    m_v[i] = 0;
                    m_x[i] = 0;
                    m_t[i] = 2'd0;
                end
                m_next = cyc + eff(int'(speed)) - 1;
            end
        end else begin
            tk = (m_next == cyc - 1);
            if (tk) m_next = cyc - 1 + eff(int'(speed));
            if (crash)   m_state = 2;
            else if (tk) do_move(l);
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    function automatic logic [63:0] dut_vec();
        return {20'd0, tick, running, obs0_valid, obs0_x, obs0_type,
                obs1_valid, obs1_x, obs1_type, passed};
    endfunction

    function automatic logic [63:0] exp_vec();
        logic           et, er, v0, v1;
        logic [X_W-1:0] x0, x1;
        et = (m_state == 1) && (m_next == cyc);
        er = (m_state == 1);
        v0 = m_v[0];
        v1 = m_v[1];
        x0 = X_W'(m_x[0]);
        x1 = X_W'(m_x[1]);
        return {20'd0, et, er, v0, x0, m_t[0], v1, x1, m_t[1], 16'(m_passed)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("outs", dut_vec(), exp_vec());
    endtask

    task automatic wait_tick(input string tag, output int w);
        w = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tick) begin
                w = cyc;
                break;
            end
        end
        if (w < 0) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int entry, w1, w2, w3, w4, wr, x_hold;
        rstn  = 1'b1;
        start = 1'b0;
        crash = 1'b0;
        speed = 21'd12;
        #1 rstn = 1'b0;
        model_reset();
        #1;
        check("reset_outs", dut_vec(), 64'd0);
        check("reset_running", running, 0);
        repeat (3) step();
        rstn = 1'b1;
        repeat (2) step();

        // Entry latency, latched period across a mid-period change, clamp, first spawn.
        start = 1'b1;
        step();
        start = 1'b0;
        entry = cyc;
        check("running_after_start", running, 1);
        wait_tick("t1", w1);
        check("first_tick_edges", w1 + 1 - entry, 12);
        repeat (3) step();
        speed = 21'd9;
        wait_tick("t2", w2);
        check("spacing_latched", w2 - w1, 12);
        step();
        speed = 21'd3;
        wait_tick("t3", w3);
        check("spacing_new", w3 - w2, 9);
        step();
        check("spawn_v0", obs0_valid, 1);
        check("spawn_x0", obs0_x, SW - 1);
        check("spawn_v1", obs1_valid, 0);
        wait_tick("t4", w4);
        check("spacing_clamp", w4 - w3, MINP);

        // Let obstacles retire, then crash exactly on a tick.
        speed = 21'd10;
        repeat (400) step();
        for (int i = 0; i < 200; i++) begin
            if (m_state == 1 && m_next == cyc && m_v[0]) break;
            step();
        end
        check("tick_due_before_crash", tick, 1);
        x_hold = m_x[0];
        crash  = 1'b1;
        step();
        crash  = 1'b0;
        check("crash_running", running, 0);
        check("crash_x_frozen", obs0_x, X_W'(x_hold));
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt_tick", tick, 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_passed", passed, 0);
        check("restart_slots", {obs0_valid, obs1_valid}, 2'b00);
        wait_tick("restart", wr);

        // Randomised run with speed changes, crashes, restarts and a mid-run reset.
        for (int n = 0; n < 15000; n++) begin
            if ($urandom_range(0, 19) == 0) speed = 21'($urandom_range(0, 14));
            start = ($urandom_range(0, 39) == 0);
            crash = ($urandom_range(0, 1499) == 0) ||
                    ((m_state == 1) && (m_next == cyc) && ($urandom_range(0, 199) == 0));
            if (n == 7000) begin
                rstn = 1'b0;
                model_reset();
                #1;
                check("mid_reset", dut_vec(), 64'd0);
                step();
                rstn = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
